// File: rtl/regfile_param.sv
// rtl/regfile_param.sv - parametrised register file with registered reads and a debug-dump stream engine
// Optional write-to-read bypass selected by defining REGFILE_BYPASS_EN.
module regfile_param #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 3,
  parameter int ZERO_REG = 0
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              RFwrite,
  input  logic [ADDR_W-1:0] regA,
  input  logic [ADDR_W-1:0] regB,
  input  logic [ADDR_W-1:0] regDisp,
  input  logic [ADDR_W-1:0] regW,
  input  logic [DATA_W-1:0] dataW,
  output logic [DATA_W-1:0] dataA,
  output logic [DATA_W-1:0] dataB,
  output logic [DATA_W-1:0] dataDisp,
  input  logic              dump_start,
  input  logic              dump_ready,
  output logic              dump_valid,
  output logic [ADDR_W-1:0] dump_idx,
  output logic [DATA_W-1:0] dump_data,
  output logic              dump_busy
);
  localparam int NUM_REGS = 2 ** ADDR_W;

  typedef enum logic [1:0] {IDLE, FETCH, SEND} state_t;

  state_t            state, state_next;
  logic [DATA_W-1:0] regs [NUM_REGS];
  logic              wr_en;

  assign wr_en = RFwrite && !(ZERO_REG != 0 && regW == '0);

  // Array read with the zero-register rule; the dump engine uses this directly.
  function automatic logic [DATA_W-1:0] array_read(input logic [ADDR_W-1:0] idx);
    if (ZERO_REG != 0 && idx == '0) return '0;
    return regs[idx];
  endfunction

  function automatic logic [DATA_W-1:0] port_read(input logic [ADDR_W-1:0] idx);
    if (ZERO_REG != 0 && idx == '0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (RFwrite && idx == regW) return dataW;
`endif
    return regs[idx];
  endfunction

  always_ff @(posedge CLK) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      dataA    <= '0;
      dataB    <= '0;
      dataDisp <= '0;
    end else begin
      dataA    <= port_read(regA);
      dataB    <= port_read(regB);
      dataDisp <= port_read(regDisp);
      if (wr_en) regs[regW] <= dataW;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (dump_start) state_next = FETCH;
      FETCH:   state_next = SEND;
      SEND:    if (dump_ready) state_next = (dump_idx == '1) ? IDLE : FETCH;
      default: state_next = IDLE;
    endcase
  end

  assign dump_valid = (state == SEND);
  assign dump_busy  = (state != IDLE);

  // dump_data is only loaded in FETCH, so CPU writes during a stalled SEND never disturb it.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state     <= IDLE;
      dump_idx  <= '0;
      dump_data <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && dump_start) dump_idx <= '0;
      if (state == FETCH) dump_data <= array_read(dump_idx);
      if (state == SEND && dump_ready && dump_idx != '1) dump_idx <= dump_idx + 1'b1;
    end
  end

endmodule

// File: tb/tb_regfile_param.sv
// tb/tb_regfile_param.sv - self-checking bench for regfile_param (ZERO_REG=0 and ZERO_REG=1 side by side)
module tb_regfile_param;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic CLK = 1'b0, reset = 1'b1, RFwrite = 1'b0, dump_start = 1'b0, dump_ready = 1'b0;
  logic [2:0]  regA = '0, regB = '0, regDisp = '0, regW = '0;
  logic [15:0] dataW = '0;
  logic [1:0][15:0] dA, dB, dD, dData;
  logic [1:0][2:0]  dIdx;
  logic [1:0]       dValid, dBusy;

  int checks = 0, failures = 0;
  bit cmp_en = 1'b0;

  always #5 CLK = ~CLK;

  regfile_param #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(0)) dut0 (
    .CLK(CLK), .reset(reset), .RFwrite(RFwrite), .regA(regA), .regB(regB), .regDisp(regDisp),
    .regW(regW), .dataW(dataW), .dataA(dA[0]), .dataB(dB[0]), .dataDisp(dD[0]),
    .dump_start(dump_start), .dump_ready(dump_ready), .dump_valid(dValid[0]),
    .dump_idx(dIdx[0]), .dump_data(dData[0]), .dump_busy(dBusy[0]));

  regfile_param #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(1)) dut1 (
    .CLK(CLK), .reset(reset), .RFwrite(RFwrite), .regA(regA), .regB(regB), .regDisp(regDisp),
    .regW(regW), .dataW(dataW), .dataA(dA[1]), .dataB(dB[1]), .dataDisp(dD[1]),
    .dump_start(dump_start), .dump_ready(dump_ready), .dump_valid(dValid[1]),
    .dump_idx(dIdx[1]), .dump_data(dData[1]), .dump_busy(dBusy[1]));

  // Reference model: index 0 = plain file, index 1 = hard-wired zero register.
  logic [15:0] mem [2][8];
  logic [15:0] eA [2], eB [2], eD [2], mData [2];
  logic [2:0]  mIdx [2];
  bit          mBusy [2], mValid [2];

  function automatic logic [15:0] rd(input int z, input logic [2:0] idx, input bit byp);
    if (z == 1 && idx == 3'd0) return 16'h0000;
    if (byp && RFwrite && regW == idx) return dataW;
    return mem[z][idx];
  endfunction

  always @(posedge CLK) begin
    for (int z = 0; z < 2; z++) begin
      if (reset) begin
        for (int i = 0; i < 8; i++) mem[z][i] = 16'h0000;
        eA[z] = 0; eB[z] = 0; eD[z] = 0; mData[z] = 0; mIdx[z] = 0;
        mBusy[z] = 0; mValid[z] = 0;
      end else begin
        eA[z] = rd(z, regA, BYP);
        eB[z] = rd(z, regB, BYP);
        eD[z] = rd(z, regDisp, BYP);
        if (!mBusy[z]) begin
          if (dump_start) begin mBusy[z] = 1; mIdx[z] = 0; mValid[z] = 0; end
        end else if (!mValid[z]) begin
          mData[z] = rd(z, mIdx[z], 1'b0);
          mValid[z] = 1;
        end else if (dump_ready) begin
          mValid[z] = 0;
          if (mIdx[z] == 3'd7) mBusy[z] = 0;
          else mIdx[z] = mIdx[z] + 3'd1;
        end
        if (RFwrite && !(z == 1 && regW == 3'd0)) mem[z][regW] = dataW;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (cmp_en) begin
      for (int z = 0; z < 2; z++) begin
        chk($sformatf("dataA[%0d]", z), {16'h0, dA[z]}, {16'h0, eA[z]});
        chk($sformatf("dataB[%0d]", z), {16'h0, dB[z]}, {16'h0, eB[z]});
        chk($sformatf("dataDisp[%0d]", z), {16'h0, dD[z]}, {16'h0, eD[z]});
        chk($sformatf("dump_valid[%0d]", z), {31'h0, dValid[z]}, {31'h0, mValid[z]});
        chk($sformatf("dump_busy[%0d]", z), {31'h0, dBusy[z]}, {31'h0, mBusy[z]});
        if (mValid[z]) begin
          chk($sformatf("dump_idx[%0d]", z), {29'h0, dIdx[z]}, {29'h0, mIdx[z]});
          chk($sformatf("dump_data[%0d]", z), {16'h0, dData[z]}, {16'h0, mData[z]});
        end
      end
    end
  end

  task automatic neg();
    @(negedge CLK);
    RFwrite = 1'b0;
    dump_start = 1'b0;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_dump(input int want_idx);
    bit ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (dValid[0] && dIdx[0] == 3'(want_idx)) begin ok = 1'b1; break; end
      step();
    end
    chk("wait_dump_idx", {31'h0, ok}, 32'd1);
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (!dBusy[0] && !dBusy[1]) begin ok = 1'b1; break; end
      step();
    end
    chk("wait_idle", {31'h0, ok}, 32'd1);
  endtask

  initial begin
    int nvalid, busy_fall;
    step();
    cmp_en = 1'b1;
    chk("reset_valid", {30'h0, dValid}, 32'd0);
    chk("reset_busy", {30'h0, dBusy}, 32'd0);
    neg(); reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      neg(); regA = 3'(i); regB = 3'(7 - i); regDisp = 3'(i);
      step();
      chk("reset_read", {dA[0], dB[1]}, 32'd0);
    end

    neg(); RFwrite = 1; regW = 3; dataW = 16'hBEEF; regA = 3; regB = 0;
    step();
    chk("collision_A", {16'h0, dA[0]}, BYP ? 32'h0000BEEF : 32'h0);
    neg(); regB = 3;
    step();
    chk("after_write_B", {16'h0, dB[0]}, 32'h0000BEEF);

    neg(); RFwrite = 1; regW = 0; dataW = 16'h1234; regA = 1;
    step();
    neg(); regA = 0;
    step();
    chk("zero_reg_off", {16'h0, dA[0]}, 32'h00001234);
    chk("zero_reg_on", {16'h0, dA[1]}, 32'h0);

    for (int n = 0; n < 400; n++) begin
      neg();
      RFwrite = 1'($urandom_range(0, 1));
      regW = 3'($urandom_range(0, 7)); dataW = 16'($urandom_range(0, 65535));
      regA = 3'($urandom_range(0, 7)); regB = 3'($urandom_range(0, 7));
      regDisp = ($urandom_range(0, 1) == 1) ? regW : 3'($urandom_range(0, 7));
      dump_start = ($urandom_range(0, 15) == 0);
      dump_ready = ($urandom_range(0, 3) != 0);
      reset = ($urandom_range(0, 149) == 0);
      step();
    end
    neg(); reset = 1'b0; dump_ready = 1'b1;
    wait_idle();

    for (int i = 0; i < 8; i++) begin
      neg(); RFwrite = 1; regW = 3'(i); dataW = 16'h1000 + 16'(i);
      step();
    end
    neg(); dump_ready = 1; dump_start = 1;
    step();
    neg();
    nvalid = 0; busy_fall = -1;
    for (int k = 1; k <= 18; k++) begin
      step();
      chk("full_valid_pattern", {31'h0, dValid[0]}, {31'h0, (k % 2 == 1) && (k < 16)});
      if (dValid[0]) begin
        chk("full_idx", {29'h0, dIdx[0]}, 32'(nvalid));
        chk("full_data0", {16'h0, dData[0]}, 32'h1000 + 32'(nvalid));
        chk("full_data1", {16'h0, dData[1]}, (nvalid == 0) ? 32'h0 : 32'h1000 + 32'(nvalid));
        nvalid++;
      end
      if (busy_fall < 0 && !dBusy[0]) busy_fall = k;
    end
    chk("full_words", 32'(nvalid), 32'd8);
    chk("full_busy_fall", 32'(busy_fall), 32'd16);

    neg(); dump_ready = 1; dump_start = 1;
    step();
    neg();
    wait_dump(2);
    neg(); dump_ready = 0; RFwrite = 1; regW = 2; dataW = 16'hFFFF;
    step();
    chk("stall_data", {16'h0, dData[0]}, 32'h00001002);
    for (int i = 0; i < 4; i++) begin
      neg(); step();
      chk("stall_data", {16'h0, dData[0]}, 32'h00001002);
      chk("stall_idx", {29'h0, dIdx[0]}, 32'd2);
    end
    neg(); dump_ready = 1; regA = 2;
    chk("accepted_word", {16'h0, dData[0]}, 32'h00001002);
    step();
    chk("r2_after_stall", {16'h0, dA[0]}, 32'h0000FFFF);
    wait_idle();

    neg(); dump_start = 1;
    step();
    neg();
    wait_dump(4);
    neg(); reset = 1;
    step();
    chk("mid_reset_valid", {30'h0, dValid}, 32'd0);
    chk("mid_reset_busy", {30'h0, dBusy}, 32'd0);
    neg(); reset = 0;
    for (int i = 0; i < 8; i++) begin
      neg(); regA = 3'(i); regB = 3'(i); regDisp = 3'(i);
      step();
      chk("post_reset_read", {dA[0], dD[0]}, 32'd0);
    end
    neg(); dump_start = 1;
    step();
    neg();
    nvalid = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (dValid[0]) begin
        chk("post_reset_dump", {16'h0, dData[0]}, 32'd0);
        nvalid++;
      end
    end
    chk("post_reset_words", 32'(nvalid), 32'd8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/regfile_param.md
# regfile_param

Parametrised register file: the successor to the fixed 8×16 register file in the CPU datapath. Width and depth are parameters. It has two registered read ports, a display read port and one write port. It adds an optional hard-wired zero register, optional write-to-read bypass, and a sequential debug-dump engine. The dump engine streams every register out over a valid/ready handshake, for the FPGA display/UART path.

## Interface
- DATA_W, 16, register width in bits
- ADDR_W, 3, register index width; NUM_REGS = 2**ADDR_W
- ZERO_REG, 0, if 1 register 0 always reads 0 and writes to it are discarded

- CLK  in  1  CPU clock; all state updates on posedge
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high
- RFwrite  in  1  write enable for regW
- regA, regB, regDisp  in  ADDR_W  read indices
- regW  in  ADDR_W  write index
- dataW  in  DATA_W  write data
- dataA, dataB, dataDisp  out  DATA_W  registered read data
- dump_start  in  1  one-cycle pulse; begin full register dump
- dump_ready  in  1  consumer accepts current dump word
- dump_valid  out  1  dump_idx/dump_data valid
- dump_idx  out  ADDR_W  index of register being dumped
- dump_data  out  DATA_W  snapshot of register dump_idx
- dump_busy  out  1  dump engine not IDLE

## Operation
- **Reset.** On a posedge with reset=1:
  - all NUM_REGS registers go to 0;
  - dataA, dataB and dataDisp go to 0;
  - dump_valid, dump_busy, dump_idx and dump_data go to 0;
  - the FSM goes to IDLE.
  - Reset overrides RFwrite and dump_start on the same edge.
- **Write.** If RFwrite=1 at a posedge, register[regW] <= dataW. With ZERO_REG=1 and regW=0, the write is discarded.
- **Read.** At each posedge, dataA <= register[regA]; the same applies to dataB/regB and dataDisp/regDisp. A read of index 0 with ZERO_REG=1 returns 0.
- **Bypass.** The read/write collision rule is selected by the macro in Configuration.
- **Dump FSM states:** IDLE, FETCH, SEND.
  - **IDLE:** dump_start=1 -> dump_idx<=0, go to FETCH. dump_start is ignored in FETCH and SEND.
  - **FETCH** (1 cycle): dump_data <= register[dump_idx]. This is the pre-write array value, with the ZERO_REG rule applied. Go to SEND.
  - **SEND:** dump_valid=1.
    - While dump_ready=0: hold dump_idx and dump_data stable, even if the CPU writes that register.
    - On dump_valid&&dump_ready with dump_idx==NUM_REGS-1: go to IDLE.
    - On dump_valid&&dump_ready otherwise: dump_idx<=dump_idx+1, go to FETCH.
  - dump_busy=1 in FETCH and SEND.
  - dump_valid is 0 in IDLE and FETCH.
- **Interaction with CPU ports.** The dump engine uses its own read mux. CPU reads and writes are never stalled or blocked by a dump.
- **dump_idx.** Never wraps: the last handshake returns the FSM to IDLE.

## Timing
- **Read latency:** 1 cycle. Indices presented in cycle c give data at outputs after the posedge ending c.
- **Write commit:** at the posedge ending the cycle in which RFwrite=1.
- **Same-cycle read of regW (collision):** returns the old value without bypass, dataW with bypass.
- **Read in cycle c+1:** always returns the new value.
- **Dump throughput:** 2 cycles per register with dump_ready held high.
  - A full dump takes 2·NUM_REGS cycles from the dump_start edge to dump_busy=0.
  - With the defaults that is 16 cycles.
- **dump_start in IDLE:** dump_busy rises at the next posedge. dump_valid rises one posedge later.
- **Reset mid-dump:** outputs equal reset values after that single posedge. Subsequent dump_start behaves normally.

## Configuration
- **REGFILE_BYPASS_EN defined:**
  - When RFwrite=1 and regW equals regA, dataA takes dataW that edge. Likewise for regB/dataB and regDisp/dataDisp.
  - The exception is regW=0 with ZERO_REG=1, which still reads 0.
  - The dump FETCH read is never bypassed.
- **REGFILE_BYPASS_EN undefined:** colliding reads return the pre-write value. This is the behaviour of the previous-generation file.

## Test plan
- **Reset:** reset 1 cycle, then read all 8 indices on regA/regB/regDisp -> every output 0x0000; dump_valid=0, dump_busy=0.
- **Write/read collision:** write r3=0xBEEF in cycle c with regA=3 in the same cycle -> dataA=0xBEEF with REGFILE_BYPASS_EN, 0x0000 without. regB=3 in cycle c+1 -> dataB=0xBEEF in both builds.
- **Zero register:** ZERO_REG=1; write r0=0x1234, then read r0 -> 0x0000. Dump word 0 -> 0x0000. ZERO_REG=0, same stimulus -> 0x1234.
- **Full dump:**
  - Stimulus: write r_i=0x1000+i for i=0..7; pulse dump_start; dump_ready tied high.
  - Required: 8 handshakes with idx 0..7 and data 0x1000..0x1007; dump_valid high every other cycle; dump_busy low exactly 16 cycles after the start edge.
- **Backpressure:** hold dump_ready low for 5 cycles at idx 2 and write r2=0xFFFF during the stall -> dump_data stays 0x1002 throughout; accepted word is 0x1002; the next read of r2 on regA returns 0xFFFF.
- **Reset mid-dump:** assert reset when dump_idx=4 in SEND -> after that edge dump_valid=0, dump_busy=0, and all registers read 0. A new dump_start then streams eight 0x0000 words.
